// File: rtl/debug_dual_port_ram_pkg.sv
// Shared helpers for the debug dual-port word RAM: default depth, byte-lane
// merge and the word-address range test.
package ram_pkg;

    localparam int BRAMWORDS = 4096;
    localparam int BRAM_AW   = $clog2(BRAMWORDS);

    // Lanes with be[i] set take new_word, the rest keep old_word.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    // In range when every address bit above the word index is zero.
    function automatic logic in_range(input logic [31:0] addr,
                                      input int unsigned aw = BRAM_AW);
        return (addr >> (aw + 32'd2)) == 32'd0;
    endfunction

endpackage

// File: rtl/debug_dual_port_ram_if.sv
// Port bundle for the debug dual-port RAM: CPU port 1 and debug port 2,
// with the debug-side status outputs.
interface debug_dual_port_ram_if;

    logic [31:0] A1;
    logic [31:0] WD1;
    logic [3:0]  WE1;
    logic        RE1;
    logic [31:0] RD1;

    logic [31:0] A2;
    logic [31:0] WD2;
    logic [3:0]  WE2;
    logic [31:0] RD2;
    logic        RD2_VALID;
    logic        OOR2;
    logic        COLLIDE;
    logic [15:0] WCNT2;

    modport master (
        output A1, WD1, WE1, RE1, A2, WD2, WE2,
        input  RD1, RD2, RD2_VALID, OOR2, COLLIDE, WCNT2
    );

    modport slave (
        input  A1, WD1, WE1, RE1, A2, WD2, WE2,
        output RD1, RD2, RD2_VALID, OOR2, COLLIDE, WCNT2
    );

endinterface

// File: rtl/debug_dual_port_ram.sv
// Byte-writable 32-bit dual-port RAM: port 1 for the CPU pipeline, port 2 for
// the debug loader/dumper, read-first with registered read data and status.
module debug_dual_port_ram
    import ram_pkg::*;
#(
    parameter int WORDS           = BRAMWORDS,
    parameter int AW              = 12,
    parameter bit COLLIDE_P2_WINS = 1'b1
) (
    input logic                  CPU_CLK,
    input logic                  CPU_RST_N,
    debug_dual_port_ram_if.slave bus
);

    logic [31:0]   mem [WORDS];

    logic [AW-1:0] idx1, idx2;
    logic          ok1, ok2;
    logic          collide_now;
    logic [3:0]    be1, be2;
    logic [31:0]   wdata2;

    logic [31:0]   rd1_d, rd1_q;
    logic [31:0]   rd2_d, rd2_q;
    logic          valid_q;
    logic          oor2_d, oor2_q;
    logic          collide_d, collide_q;
    logic [15:0]   wcnt2_d, wcnt2_q;

    assign idx1 = bus.A1[AW+1:2];
    assign idx2 = bus.A2[AW+1:2];

    // A collision is folded into a single port-2 write of the merged word, so
    // the two ports never drive the same lane in one edge.
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        ok1         = in_range(bus.A1, AW);
        ok2         = in_range(bus.A2, AW);
        collide_now = ok1 && ok2 && (idx1 == idx2) && ((bus.WE1 & bus.WE2) != 4'h0);

        be1    = (ok1 && !collide_now) ? bus.WE1 : 4'h0;
        be2    = !ok2 ? 4'h0 : (collide_now ? (bus.WE1 | bus.WE2) : bus.WE2);
        wdata2 = bus.WD2;
        if (collide_now) begin
            wdata2 = COLLIDE_P2_WINS ? byte_merge(bus.WD1, bus.WD2, bus.WE2)
                                     : byte_merge(bus.WD2, bus.WD1, bus.WE1);
        end

        rd1_d = rd1_q;
        if (bus.RE1) rd1_d = ok1 ? mem[idx1] : 32'h0;
        rd2_d = ok2 ? mem[idx2] : 32'h0;

        oor2_d    = oor2_q | ~ok2;
        collide_d = collide_q | collide_now;
        wcnt2_d   = wcnt2_q;
        if (ok2 && (bus.WE2 != 4'h0) && (wcnt2_q != 16'hFFFF)) wcnt2_d = wcnt2_q + 16'd1;
    end

    // NOTE: the array has no reset branch -- its contents survive reset and only writes are gated.
    // NOTE: sequential state uses non-blocking assignments so the read-first value is the pre-edge word.
    always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
        if (!CPU_RST_N) begin
            rd1_q     <= 32'h0;
            rd2_q     <= 32'h0;
            valid_q   <= 1'b0;
            oor2_q    <= 1'b0;
            collide_q <= 1'b0;
            wcnt2_q   <= 16'h0;
        end else begin
            rd1_q     <= rd1_d;
            rd2_q     <= rd2_d;
            valid_q   <= 1'b1;
            oor2_q    <= oor2_d;
            collide_q <= collide_d;
            wcnt2_q   <= wcnt2_d;
            for (int i = 0; i < 4; i++) begin
                if (be1[i]) mem[idx1][8*i +: 8] <= bus.WD1[8*i +: 8];
                if (be2[i]) mem[idx2][8*i +: 8] <= wdata2[8*i +: 8];
            end
        end
    end

    assign bus.RD1       = rd1_q;
    assign bus.RD2       = rd2_q;
    assign bus.RD2_VALID = valid_q;
    assign bus.OOR2      = oor2_q;
    assign bus.COLLIDE   = collide_q;
    assign bus.WCNT2     = wcnt2_q;

endmodule

// File: doc/debug_dual_port_ram.md
Name: debug_dual_port_ram

Overview:
- Byte-writable 32-bit dual-port word RAM used for both InstRAM and DataRAM instances inside the RV32 core.
- Port 1 serves the CPU pipeline. Port 2 is the debug responder: it services the host-side loader/dumper that drives the Debug_*RAM_A2/WD2/WE2 interface, and returns RD2.
- Adds registered read data with a valid strobe, a defined collision policy, range checking, and debug-side status counters so load and dump sequences are observable.

Parameters:
- WORDS, 4096, number of 32-bit words; must be a power of two.
- AW, 12, word-address width, equal to log2(WORDS).
- COLLIDE_P2_WINS, 1, same-word same-byte write collision: 1 means port 2 data is stored, 0 means port 1 data is stored.

Ports:
- CPU_CLK  in  1  single clock for both ports.
- CPU_RST_N  in  1  asynchronous, active-low reset.
- A1  in  32  port 1 byte address.
- WD1  in  32  port 1 write data.
- WE1  in  4  port 1 byte write enables; bit i controls byte lane [8i+7:8i].
- RE1  in  1  port 1 read enable.
- RD1  out  32  port 1 registered read data.
- A2  in  32  debug byte address.
- WD2  in  32  debug write data.
- WE2  in  4  debug byte write enables.
- RD2  out  32  debug registered read data; the port always reads.
- RD2_VALID  out  1  high in the cycle after a port 2 read is sampled.
- OOR2  out  1  sticky flag: port 2 accessed an address at or above WORDS*4.
- COLLIDE  out  1  sticky flag: both ports wrote at least one common byte of the same word in the same cycle.
- WCNT2  out  16  count of port 2 cycles with WE2 != 0 and address in range; saturates at 0xFFFF.

Behaviour:
- Address decode: word index = A[AW+1:2]. A[1:0] is ignored.
- Range check: the address is in range when A[31:AW+2] == 0.
- Out-of-range write: dropped; the array is unchanged.
- Out-of-range read: returns 0x00000000 on the following cycle. On port 2 it also sets OOR2.
- Writes: on posedge CPU_CLK, each enabled byte lane of an in-range address is written. Disabled lanes keep their value.
- Read latency is 1 cycle, read-first. RD reflects the array contents before any write in the same edge, on the same port and on the other port.
- RD1 updates only when RE1=1; otherwise it holds its value.
- RD2 updates every cycle. RD2_VALID is 0 for the first cycle after reset deassertion and 1 on every cycle thereafter.
- Collision: same word index, both in range, and (WE1 & WE2) != 0.
  - Overlapping lanes take data from the port selected by COLLIDE_P2_WINS.
  - Non-overlapping lanes take data from their own port.
  - COLLIDE is set.
- Sticky flags: OOR2 and COLLIDE clear only on reset.
- Reset values: RD1=0, RD2=0, RD2_VALID=0, OOR2=0, COLLIDE=0, WCNT2=0.
- Reset and the array: reset does not initialise the array; its contents are retained across reset.
- Writes during reset: any write presented while CPU_RST_N=0 is dropped.
- Reset mid-operation: asserting reset immediately clears all registered outputs, with no clock required. The first write after deassertion takes effect at the first posedge at which CPU_RST_N=1.
- Address wrap: the word index does not wrap. A2 = WORDS*4 is out of range. A2 = WORDS*4-4 is the last valid word.
- WCNT2 saturation: WCNT2 stays at 0xFFFF once reached.
- Simulation: the array initialises to X. A dump of unwritten words shows X.

Decomposition:
- Shared package ram_pkg holds:
  - localparam BRAMWORDS=4096
  - function byte_merge(old, new, be), returning 32 bits
  - function in_range(addr), returning 1 bit
- No sub-module is required. The storage array and both port processes sit in one module so synthesis can infer true-dual-port BRAM.
- Collision resolution uses the byte_merge helper; it is not a separate block.

Test Plan:
- Reset, then write A2=0x0 with WD2=0xDEADBEEF and WE2=0xF; read A2=0x0 next cycle -> RD2=0xDEADBEEF one cycle later, RD2_VALID=1, WCNT2=1.
- Byte enables: write WD2=0x11223344 with WE2=0b0101 over a word holding 0xFFFFFFFF -> the word reads 0xFF22FF44.
- Read-first: in one cycle, write 0xAAAAAAAA on port 1 to word 5 while port 2 reads word 5, which held 0x12345678 -> RD2=0x12345678; the next read returns 0xAAAAAAAA.
- Collision with COLLIDE_P2_WINS=1: WE1=0xF with WD1=0x11111111, and WE2=0x3 with WD2=0x22222222, same word -> the word reads 0x11112222 and COLLIDE=1.
- Out of range: write A2=0x4000 with WE2=0xF -> the array is unchanged, RD2=0, OOR2=1, WCNT2 does not increment.
- Load and dump: stream 4096 sequential words (data = index) through port 2 at one per cycle, then read them all back -> every RD2 equals its index and WCNT2=4096. Pulse CPU_RST_N low mid-dump -> RD2=0 and RD2_VALID=0 immediately, and the array contents are still intact on re-read.
